// File: rtl/dmem_req_unit.sv
`default_nettype none
// ============================================================================
// Module   : dmem_req_unit
// Brief    : Data-memory request FSM (IDLE/REQ/WAIT) with alignment, byte
//            lanes, flush suppression and response timeout.
// Revision : 1.0
// ============================================================================
module dmem_req_unit #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_width_i,
    input  logic        flush_i,
    output logic        dmem_req_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    output logic        done_o,
    output logic        misalign_o,
    output logic        timeout_o,
    output logic        busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [7:0] C_MAX_WAIT = 8'(MAX_WAIT);

    logic [1:0]  r_state;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [7:0]  r_cnt;
    logic        r_suppress;
    logic        r_done;
    logic        r_misalign;
    logic        r_timeout;

    logic        w_accept;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_cnt_next;
    logic        w_req_done;

    assign w_accept = req_valid_i && (r_state == S_IDLE);

    always_comb begin
        w_misalign = 1'b0;
        w_be       = 4'b0000;
        w_wdata    = req_wdata_i;
        case (req_width_i)
            2'd0: begin
                w_be    = 4'b0001 << req_addr_i[1:0];
                w_wdata = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                w_misalign = req_addr_i[0];
                w_be       = 4'b0011 << {req_addr_i[1], 1'b0};
                w_wdata    = {2{req_wdata_i[15:0]}};
            end
            2'd2: begin
                w_misalign = (req_addr_i[1:0] != 2'b00);
                w_be       = 4'b1111;
            end
            default: w_misalign = 1'b1;
        endcase
    end

    // Saturating so a large MAX_WAIT can never alias through a wrap.
    assign w_cnt_next = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    // Grant and response in the same REQ cycle complete immediately.
    assign w_req_done = (r_state == S_REQ) && dmem_gnt_i && dmem_rvalid_i
                        && !flush_i && !r_suppress;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_be       <= 4'd0;
            r_wdata    <= 32'd0;
            r_cnt      <= 8'd0;
            r_suppress <= 1'b0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_misalign) begin
                            r_misalign <= 1'b1;
                        end else begin
                            r_state    <= S_REQ;
                            r_we       <= req_we_i;
                            r_addr     <= {req_addr_i[31:2], 2'b00};
                            r_be       <= w_be;
                            r_wdata    <= w_wdata;
                            r_suppress <= 1'b0;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt_i) begin
                        if (dmem_rvalid_i) begin
                            r_state    <= S_IDLE;
                            r_suppress <= 1'b0;
                        end else begin
                            r_state    <= S_WAIT;
                            r_cnt      <= 8'd0;
                            r_suppress <= r_suppress | flush_i;
                        end
                    end else if (flush_i) begin
                        r_state    <= S_IDLE;
                        r_suppress <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid_i) begin
                        r_state    <= S_IDLE;
                        r_done     <= !(r_suppress || flush_i);
                        r_suppress <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == C_MAX_WAIT) begin
                            r_state    <= S_IDLE;
                            r_timeout  <= 1'b1;
                            r_suppress <= 1'b0;
                        end else begin
                            r_suppress <= r_suppress | flush_i;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_suppress <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = (r_state == S_IDLE);
    assign busy_o       = (r_state != S_IDLE);
    assign dmem_req_o   = (r_state == S_REQ);
    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_be_o    = r_be;
    assign dmem_wdata_o = r_wdata;
    assign done_o       = r_done | w_req_done;
    assign misalign_o   = r_misalign;
    assign timeout_o    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_dmem_req_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_req_unit
// Brief    : Directed plus randomized self-checking bench for dmem_req_unit.
// Revision : 1.0
// ============================================================================
module tb_dmem_req_unit;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [1:0]  req_width_i = '0;
    logic        flush_i = 1'b0;
    logic        dmem_req_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        done_o;
    logic        misalign_o;
    logic        timeout_o;
    logic        busy_o;

    dmem_req_unit #(.MAX_WAIT(MW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_width_i  (req_width_i),
        .flush_i      (flush_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_gnt_i   (dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .done_o       (done_o),
        .misalign_o   (misalign_o),
        .timeout_o    (timeout_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Transaction-level model: phase 0 = idle, 1 = request outstanding,
    // 2 = granted and awaiting response.
    int          m_ph = 0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [3:0]  m_be = '0;
    logic [31:0] m_wd = '0;
    int          m_waited = 0;
    bit          m_sq = 1'b0;
    bit          m_pd = 1'b0;
    bit          m_pm = 1'b0;
    bit          m_pt = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_misaligned(input logic [1:0] w, input logic [31:0] a);
        return (w == 2'd3) || (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [3:0] be_of(input logic [1:0] w, input logic [31:0] a);
        case (w)
            2'd0:    return 4'b0001 << a[1:0];
            2'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wd_of(input logic [1:0] w, input logic [31:0] d);
        case (w)
            2'd0:    return {24'd0, d[7:0]} * 32'h0101_0101;
            2'd1:    return {16'd0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = 0; m_sq = 0; m_pd = 0; m_pm = 0; m_pt = 0; m_waited = 0;
    endtask

    task automatic compare_and_advance();
        bit exp_done;
        exp_done = m_pd || (m_ph == 1 && dmem_gnt_i && dmem_rvalid_i && !flush_i && !m_sq);
        chk("ready", req_ready_o, m_ph == 0);
        chk("busy", busy_o, m_ph != 0);
        chk("dmem_req", dmem_req_o, m_ph == 1);
        chk("done", done_o, exp_done);
        chk("misalign", misalign_o, m_pm);
        chk("timeout", timeout_o, m_pt);
        if (m_ph == 1) begin
            chk("we", dmem_we_o, m_we);
            chk("addr", dmem_addr_o, m_addr);
            chk("be", dmem_be_o, m_be);
            if (m_we) chk("wdata", dmem_wdata_o, m_wd);
        end
        m_pd = 0; m_pm = 0; m_pt = 0;
        case (m_ph)
            0: if (req_valid_i) begin
                if (is_misaligned(req_width_i, req_addr_i)) m_pm = 1;
                else begin
                    m_ph   = 1;
                    m_we   = req_we_i;
                    m_addr = req_addr_i & 32'hFFFF_FFFC;
                    m_be   = be_of(req_width_i, req_addr_i);
                    m_wd   = wd_of(req_width_i, req_wdata_i);
                    m_sq   = 0;
                end
            end
            1: begin
                if (dmem_gnt_i && dmem_rvalid_i) begin
                    m_ph = 0; m_sq = 0;
                end else if (dmem_gnt_i) begin
                    m_ph = 2; m_waited = 0; m_sq = m_sq | flush_i;
                end else if (flush_i) begin
                    m_ph = 0; m_sq = 0;
                end
            end
            default: begin
                m_sq = m_sq | flush_i;
                if (dmem_rvalid_i) begin
                    m_pd = !m_sq; m_ph = 0; m_sq = 0;
                end else begin
                    m_waited++;
                    if (m_waited == MW) begin
                        m_pt = 1; m_ph = 0; m_sq = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic step();
        #1;
        compare_and_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        req_valid_i = 1; req_we_i = we; req_addr_i = a; req_wdata_i = d; req_width_i = w;
        step();
        req_valid_i = 0;
    endtask

    task automatic idle_inputs();
        req_valid_i = 0; flush_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_req", dmem_req_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_addr", dmem_addr_o, 0);
        chk("rst_be", dmem_be_o, 0);
        @(negedge clk);
        rst_ni = 1;
        model_reset();

        // Byte store, grant and response together.
        req(1, 32'h1003, 32'h0000_00A5, 2'd0);
        dmem_gnt_i = 1; dmem_rvalid_i = 1;
        #1;
        chk("sb_be", dmem_be_o, 4'b1000);
        chk("sb_wdata", dmem_wdata_o, 32'hA5A5_A5A5);
        chk("sb_addr", dmem_addr_o, 32'h1000);
        chk("sb_we", dmem_we_o, 1);
        chk("sb_done", done_o, 1);
        step();
        idle_inputs();

        // Half store with grant delayed three cycles.
        req(1, 32'h2002, 32'h0000_1234, 2'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sh_hold_req", dmem_req_o, 1);
            chk("sh_hold_be", dmem_be_o, 4'b1100);
            chk("sh_hold_wdata", dmem_wdata_o, 32'h1234_1234);
            chk("sh_hold_addr", dmem_addr_o, 32'h2000);
            step();
        end
        dmem_gnt_i = 1; step();
        dmem_gnt_i = 0; dmem_rvalid_i = 1; step();
        dmem_rvalid_i = 0;
        #1; chk("sh_done", done_o, 1);
        step();

        // Misaligned and illegal-width requests.
        req(0, 32'h3001, 32'h0, 2'd2);
        #1; chk("lw_mis", misalign_o, 1); chk("lw_mis_noreq", dmem_req_o, 0);
        step();
        #1; chk("lw_mis_once", misalign_o, 0); chk("lw_mis_noreq2", dmem_req_o, 0);
        req(0, 32'h3000, 32'h0, 2'd3);
        #1; chk("w3_mis", misalign_o, 1);
        step();

        // Timeout after MW wait cycles.
        req(0, 32'h40, 32'h0, 2'd2);
        dmem_gnt_i = 1; step();
        dmem_gnt_i = 0;
        for (int i = 0; i < MW; i++) begin
            #1; chk("to_wait", timeout_o, 0);
            step();
        end
        #1; chk("to_pulse", timeout_o, 1); chk("to_ready", req_ready_o, 1);
        step();

        // Flush while waiting suppresses done.
        req(0, 32'h50, 32'h0, 2'd2);
        dmem_gnt_i = 1; step();
        dmem_gnt_i = 0; flush_i = 1; step();
        flush_i = 0; step();
        dmem_rvalid_i = 1; step();
        dmem_rvalid_i = 0;
        #1; chk("fl_nodone", done_o, 0); chk("fl_ready", req_ready_o, 1);
        step();

        // Asynchronous reset in WAIT, late response afterwards.
        req(0, 32'h60, 32'h0, 2'd2);
        dmem_gnt_i = 1; step();
        dmem_gnt_i = 0; step();
        #2; rst_ni = 0; #1;
        chk("ar_ready", req_ready_o, 1);
        chk("ar_busy", busy_o, 0);
        chk("ar_req", dmem_req_o, 0);
        chk("ar_done", done_o, 0);
        chk("ar_timeout", timeout_o, 0);
        model_reset();
        @(posedge clk); @(negedge clk);
        rst_ni = 1; dmem_rvalid_i = 1; step();
        dmem_rvalid_i = 0;
        #1; chk("ar_late_nodone", done_o, 0);
        step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            req_valid_i = 1'($urandom_range(0, 1));
            req_we_i    = 1'($urandom_range(0, 1));
            req_addr_i  = $urandom;
            if ($urandom_range(0, 1) == 0) req_addr_i[1:0] = 2'b00;
            req_width_i = 2'($urandom_range(0, 3));
            req_wdata_i = $urandom;
            dmem_gnt_i    = ($urandom_range(0, 9) < 4);
            dmem_rvalid_i = ($urandom_range(0, 9) < 3);
            flush_i = (m_ph != 0) && ($urandom_range(0, 9) == 0);
            if (m_ph == 1 && dmem_gnt_i && dmem_rvalid_i) flush_i = 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_req_unit.md
DMEM_REQ_UNIT -- requirements
Module: dmem_req_unit

Interface
REQ-001 Parameter MAX_WAIT, default 16, SHALL set the cycles allowed in WAIT before timeout (range 1..255).
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req_valid_i  input  1  SHALL signal that a memory request from Execute is pending.
REQ-005 req_ready_o  output  1  SHALL signal that the unit can accept a request.
REQ-006 req_we_i  input  1  SHALL select the access type: 1 = store, 0 = load.
REQ-007 req_addr_i  input  32  SHALL carry the byte address.
REQ-008 req_wdata_i  input  32  SHALL carry the store data, LSB-justified.
REQ-009 req_width_i  input  2  SHALL carry the access width: 0 = BYTE, 1 = HALF, 2 = WORD, 3 = illegal.
REQ-010 flush_i  input  1  SHALL signal that the current request is squashed.
REQ-011 dmem_req_o  output  1  SHALL carry the memory request strobe.
REQ-012 dmem_gnt_i  input  1  SHALL carry the memory grant; it accepts the request in that cycle.
REQ-013 dmem_rvalid_i  input  1  SHALL carry the memory response/completion strobe.
REQ-014 dmem_we_o  output  1, dmem_addr_o  output  32, dmem_be_o  output  4 and dmem_wdata_o  output  32 SHALL carry the request attributes.
REQ-015 done_o  output  1  SHALL pulse when a transaction completes.
REQ-016 misalign_o  output  1  SHALL pulse when a request is misaligned or illegal.
REQ-017 timeout_o  output  1  SHALL pulse when the response wait expires.
REQ-018 busy_o  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, REQ, WAIT.
REQ-020 req_ready_o SHALL be 1 only in IDLE; a request is accepted on req_valid_i && req_ready_o.
REQ-021 On acceptance, the unit SHALL register we, the address, width and aligned data and byte enables; dmem_req_o SHALL rise in the next cycle.
REQ-022 Misalignment SHALL be any of: HALF with addr[0]=1, WORD with addr[1:0]!=0, or width=3.
REQ-023 On a misaligned accept, the unit SHALL pulse misalign_o for one cycle in the next cycle, stay in IDLE and issue no dmem request.
REQ-024 dmem_addr_o SHALL be {addr[31:2],2'b00}.
REQ-025 dmem_be_o SHALL be: BYTE 4'b0001<<addr[1:0]; HALF 4'b0011<<{addr[1],1'b0}; WORD 4'b1111.
REQ-026 dmem_wdata_o SHALL be: BYTE {4{wdata[7:0]}}; HALF {2{wdata[15:0]}}; WORD wdata.
REQ-027 dmem_be_o SHALL be driven for loads as well; dmem_wdata_o is don't-care for loads.
REQ-028 In REQ, dmem_req_o and all request attributes SHALL remain stable until dmem_gnt_i is sampled high.
REQ-029 REQ transitions SHALL be:
  - gnt with rvalid -> IDLE, with done_o pulsed;
  - gnt only -> WAIT, with dmem_req_o low from the next cycle.
REQ-030 WAIT transitions SHALL be:
  - rvalid -> IDLE, with done_o pulsed in the next cycle;
  - the wait counter reaching MAX_WAIT without rvalid -> IDLE, with timeout_o pulsed.
REQ-031 The wait counter SHALL clear on entry to WAIT and increment by 1 each WAIT cycle; it SHALL saturate and never wrap.
REQ-032 flush_i SHALL act as follows:
  - in REQ before or without gnt: abort to IDLE with no done_o;
  - in REQ with gnt in the same cycle: the grant stands, go to WAIT and suppress done_o;
  - in WAIT: stay until rvalid or timeout, then suppress done_o.
REQ-033 A suppression flag SHALL record a flush during REQ or WAIT and clear on return to IDLE.
REQ-034 rvalid or gnt arriving in IDLE SHALL be ignored; there are no spurious pulses.
REQ-035 done_o, misalign_o and timeout_o SHALL each be one cycle wide and mutually exclusive.
REQ-036 Back-to-back operation: after done_o, a new request SHALL be accepted in the cycle req_ready_o returns high.

Reset
REQ-037 While rst_ni=0, the unit SHALL asynchronously force:
  - state IDLE, wait counter 0, suppression flag 0;
  - all outputs 0, except req_ready_o=1.
REQ-038 Reset mid-transaction SHALL abandon the transaction; after release the unit SHALL accept a new request without waiting for rvalid.

Verification
REQ-039 SB store: addr 0x1003, wdata 0x000000A5 -> be=1000, wdata=0xA5A5A5A5, addr=0x1000, we=1; gnt+rvalid in the same cycle -> done_o in that cycle.
REQ-040 SH store: addr 0x2002, wdata 0x1234 -> be=1100, wdata=0x12341234; gnt held off 3 cycles -> attributes stable for all 3 cycles, then done_o.
REQ-041 LW at 0x3001 -> misalign_o one cycle, dmem_req_o never high; width=3 at 0x3000 -> misalign_o.
REQ-042 Load granted, no rvalid, MAX_WAIT=4 -> timeout_o after 4 WAIT cycles, then req_ready_o=1.
REQ-043 Flush during WAIT, then rvalid 2 cycles later -> IDLE, done_o stays 0.
REQ-044 rst_ni low in WAIT -> outputs 0 and req_ready_o=1 immediately, without waiting for a clock; a late rvalid after release -> no done_o.
